// File: rtl/capture_ctrl_module.sv
// -----------------------------------------------------------------------------
// capture_ctrl_module
//
// Frame-capture sequencer for the OV7620 path. Consumes HSYNC/VSYNC that have
// already been aligned upstream, tracks pixel/line position, opens a
// programmable capture window and drives the frame-buffer write strobe and
// write address. Supports single-shot and continuous capture with
// start/done/error reporting.
//
// Optional feature macro: FRAME_CNT_EN
//   defined   : FRAME_CNT counts frames that completed without ERR (wraps)
//   undefined : FRAME_CNT is tied to 0 and no counter is built
//
// Ports
//   CLK          pixel clock
//   RST          synchronous active-high reset
//   HSYNC        aligned line-valid, high = active pixels
//   VSYNC        aligned frame sync, high pulse marks frame boundary
//   ARM          one-cycle capture request (honoured in IDLE only)
//   MODE_CONT    1 = re-arm automatically after each frame
//   ABORT        one-cycle request to stop immediately (wins over ARM)
//   WIN_X0/WIN_W horizontal window start / width in pixels
//   WIN_Y0/WIN_H vertical window start / height in lines
//   WR_EN        frame-buffer write strobe (one cycle after the pixel sample)
//   WR_ADDR      address of the current write
//   FRAME_START  one-cycle pulse at capture-frame start
//   FRAME_DONE   one-cycle pulse at capture-frame end
//   BUSY         high in every state except IDLE
//   ERR          sticky short-frame flag, cleared when the next frame latches
//   FRAME_CNT    completed-frame count
//
// State     | meaning
// ----------+------------------------------------------------------------
// IDLE      | not armed, waiting for ARM
// WAIT_VS   | armed, waiting for VSYNC rise to latch the window
// VS_HI     | frame latched, waiting for VSYNC fall
// CAPTURE   | counting pixels/lines, writing pixels inside the window
// DONE      | one cycle, FRAME_DONE pulse, then WAIT_VS or IDLE
// -----------------------------------------------------------------------------
module capture_ctrl_module #(
    parameter int PX_W   = 10,
    parameter int LN_W   = 9,
    parameter int ADDR_W = 19
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HSYNC,
    input  logic              VSYNC,
    input  logic              ARM,
    input  logic              MODE_CONT,
    input  logic              ABORT,
    input  logic [PX_W-1:0]   WIN_X0,
    input  logic [PX_W-1:0]   WIN_W,
    input  logic [LN_W-1:0]   WIN_Y0,
    input  logic [LN_W-1:0]   WIN_H,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic              FRAME_START,
    output logic              FRAME_DONE,
    output logic              BUSY,
    output logic              ERR,
    output logic [15:0]       FRAME_CNT
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_VS = 3'd1,
        S_VS_HI   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Sync history; edges compare the live input with the registered copy.
    logic hs_q, vs_q;
    logic hs_fall, vs_rise, vs_fall;

    // Window shadow registers, loaded once per frame at the VSYNC rise.
    logic [PX_W-1:0] x0_q, x0_d, w_q, w_d;
    logic [LN_W-1:0] y0_q, y0_d, h_q, h_d;

    // Position counters are one bit wider than the window fields so that
    // X0+W / Y0+H can be reached without wrapping.
    logic [PX_W:0]       px_q, px_d;
    logic [LN_W:0]       line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic                fstart_q, fstart_d;
    logic                err_q, err_d;

    logic [PX_W:0]  x_lo, x_end;
    logic [LN_W:0]  y_lo, y_end, line_inc;
    logic           in_win, line_done, latch;

    assign hs_fall = hs_q & ~HSYNC;
    assign vs_rise = VSYNC & ~vs_q;
    assign vs_fall = vs_q & ~VSYNC;

    assign x_lo     = {1'b0, x0_q};
    assign x_end    = {1'b0, x0_q} + {1'b0, w_q};
    assign y_lo     = {1'b0, y0_q};
    assign y_end    = {1'b0, y0_q} + {1'b0, h_q};
    assign line_inc = line_q + 1'b1;

    assign in_win    = (px_q >= x_lo) && (px_q < x_end) &&
                       (line_q >= y_lo) && (line_q < y_end);
    assign line_done = hs_fall && (line_inc == y_end);
    assign latch     = (state_q == S_WAIT_VS) && vs_rise && !ABORT;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ARM) state_d = S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (vs_rise) state_d = S_VS_HI;
                end
                S_VS_HI: begin
                    // An empty vertical window completes as soon as the frame opens.
                    if (vs_fall) state_d = (h_q == '0) ? S_DONE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (line_done || vs_rise) state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = MODE_CONT ? S_WAIT_VS : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        FRAME_DONE = (state_q == S_DONE);
        BUSY       = (state_q != S_IDLE);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        x0_d     = x0_q;
        w_d      = w_q;
        y0_d     = y0_q;
        h_d      = h_q;
        px_d     = px_q;
        line_d   = line_q;
        addr_d   = addr_q;
        wr_en_d  = 1'b0;
        fstart_d = latch;
        err_d    = err_q;

        if (latch) begin
            x0_d  = WIN_X0;
            w_d   = WIN_W;
            y0_d  = WIN_Y0;
            h_d   = WIN_H;
            err_d = 1'b0;
        end

        if (wr_en_q) begin
            addr_d = addr_q + 1'b1;
        end

        if ((state_q == S_VS_HI) && vs_fall) begin
            px_d   = '0;
            line_d = '0;
            addr_d = '0;
        end

        if (state_q == S_CAPTURE) begin
            if (HSYNC) begin
                px_d = px_q + 1'b1;
            end
            if (hs_fall) begin
                px_d   = '0;
                line_d = line_inc;
            end
            wr_en_d = HSYNC && in_win && !vs_rise && !ABORT;
            // Line completion on the same cycle as a VSYNC rise counts as a
            // clean finish, not a short frame.
            if (vs_rise && !line_done && !ABORT) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            x0_q     <= '0;
            w_q      <= '0;
            y0_q     <= '0;
            h_q      <= '0;
            px_q     <= '0;
            line_q   <= '0;
            addr_q   <= '0;
            wr_en_q  <= 1'b0;
            fstart_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            hs_q     <= HSYNC;
            vs_q     <= VSYNC;
            x0_q     <= x0_d;
            w_q      <= w_d;
            y0_q     <= y0_d;
            h_q      <= h_d;
            px_q     <= px_d;
            line_q   <= line_d;
            addr_q   <= addr_d;
            wr_en_q  <= wr_en_d;
            fstart_q <= fstart_d;
            err_q    <= err_d;
        end
    end

    assign WR_EN       = wr_en_q;
    assign WR_ADDR     = addr_q;
    assign FRAME_START = fstart_q;
    assign ERR         = err_q;

`ifdef FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if ((state_q == S_DONE) && !err_q) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign FRAME_CNT = fcnt_q;
`else
    assign FRAME_CNT = 16'd0;
`endif

endmodule
